mfp_ahb_dma_copy: RTL

- AHB-Lite single-master block-copy engine that sits directly upstream of the AHB memory slave and drives its HTRANS/HADDR/HWRITE/HWDATA inputs.
- Copies a run of 32-bit words from a source address to a destination address as alternating SINGLE word reads and writes.
- Used for boot-time RAM preload and test buffer moves, with no CPU involvement.

---
 rtl/mfp_ahb_dma_copy.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/mfp_ahb_dma_copy.sv
`default_nettype none
// ============================================================================
// Module      : mfp_ahb_dma_copy
// Description : AHB-Lite single-master block-copy engine. Moves a run of
//               32-bit words from a source to a destination address as
//               alternating SINGLE word reads and writes, with no CPU
//               involvement (boot-time RAM preload, buffer moves).
//               Optional fill mode (macro MFP_AHB_DMA_FILL_EN) writes a
//               constant fill_value instead of copying read data.
// Revision    : 1.0 - initial release
// ============================================================================
module mfp_ahb_dma_copy #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   start,
    input  logic [31:0]            src_addr,
    input  logic [31:0]            dst_addr,
    input  logic [COUNT_WIDTH-1:0] word_count,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [31:0]            HADDR,
    output logic [1:0]             HTRANS,
    output logic [2:0]             HBURST,
    output logic [2:0]             HSIZE,
    output logic                   HWRITE,
    output logic [31:0]            HWDATA,
    input  logic [31:0]            HRDATA,
    input  logic                   HREADY,
    input  logic                   HRESP
`ifdef MFP_AHB_DMA_FILL_EN
    ,
    input  logic                   fill,
    input  logic [31:0]            fill_value
`endif
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_rd_addr = 3'd1;
    localparam logic [2:0] c_st_rd_data = 3'd2;
    localparam logic [2:0] c_st_wr_addr = 3'd3;
    localparam logic [2:0] c_st_wr_data = 3'd4;
    localparam logic [2:0] c_st_done    = 3'd5;

    localparam logic [1:0] c_htrans_idle   = 2'b00;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;

    localparam logic [COUNT_WIDTH-1:0] c_count_one  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [31:0]            c_word_bytes = 32'd4;

    logic [2:0]             r_state;
    logic [2:0]             w_next_state;
    logic [31:0]            r_src;
    logic [31:0]            r_dst;
    logic [COUNT_WIDTH-1:0] r_remaining;
    logic [31:0]            r_buf;
    logic                   r_error;
    logic                   w_fill_req;
    logic                   w_fill_mode;
    logic                   w_last_word;
    logic                   w_unused_addr_lsbs;

    // Addresses are word aligned; the byte-offset bits are dropped on latch.
    assign w_unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

    assign w_last_word = (r_remaining == c_count_one);

`ifdef MFP_AHB_DMA_FILL_EN
    logic r_fill;

    assign w_fill_req  = fill;
    assign w_fill_mode = r_fill;

    // Fill mode is captured with the job so the request pins may change afterwards.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_fill <= 1'b0;
        end else if ((r_state == c_st_idle) && start) begin
            r_fill <= fill;
        end
    end
`else
    assign w_fill_req  = 1'b0;
    assign w_fill_mode = 1'b0;
`endif

    // State register; reset aborts any outstanding transfer immediately.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: read, write, repeat until the counter runs out or the slave errors.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    if (word_count == '0) begin
                        w_next_state = c_st_done;
                    end else if (w_fill_req) begin
                        w_next_state = c_st_wr_addr;
                    end else begin
                        w_next_state = c_st_rd_addr;
                    end
                end
            end
            c_st_rd_addr: begin
                if (HREADY) begin
                    w_next_state = c_st_rd_data;
                end
            end
            c_st_rd_data: begin
                if (HRESP) begin
                    w_next_state = c_st_done;
                end else if (HREADY) begin
                    w_next_state = c_st_wr_addr;
                end
            end
            c_st_wr_addr: begin
                if (HREADY) begin
                    w_next_state = c_st_wr_data;
                end
            end
            c_st_wr_data: begin
                if (HRESP) begin
                    w_next_state = c_st_done;
                end else if (HREADY) begin
                    if (w_last_word) begin
                        w_next_state = c_st_done;
                    end else if (w_fill_mode) begin
                        w_next_state = c_st_wr_addr;
                    end else begin
                        w_next_state = c_st_rd_addr;
                    end
                end
            end
            c_st_done: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // Job registers: latched on start, advanced after each completed write; frozen on error.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_remaining <= '0;
            r_buf       <= '0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_src       <= {src_addr[31:2], 2'b00};
                        r_dst       <= {dst_addr[31:2], 2'b00};
                        r_remaining <= word_count;
                        r_error     <= 1'b0;
`ifdef MFP_AHB_DMA_FILL_EN
                        if (fill) begin
                            r_buf <= fill_value;
                        end
`endif
                    end
                end
                c_st_rd_data: begin
                    if (HRESP) begin
                        r_error <= 1'b1;
                    end else if (HREADY) begin
                        r_buf <= HRDATA;
                    end
                end
                c_st_wr_data: begin
                    if (HRESP) begin
                        r_error <= 1'b1;
                    end else if (HREADY) begin
                        r_remaining <= r_remaining - c_count_one;
                        r_src       <= r_src + c_word_bytes;
                        r_dst       <= r_dst + c_word_bytes;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bus and status outputs decoded purely from the registered state and job registers.
    always_comb begin
        HTRANS = c_htrans_idle;
        HWRITE = 1'b0;
        HADDR  = r_src;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            c_st_rd_addr: begin
                HTRANS = c_htrans_nonseq;
                busy   = 1'b1;
            end
            c_st_rd_data: begin
                busy   = 1'b1;
            end
            c_st_wr_addr: begin
                HTRANS = c_htrans_nonseq;
                HWRITE = 1'b1;
                HADDR  = r_dst;
                busy   = 1'b1;
            end
            c_st_wr_data: begin
                HADDR  = r_dst;
                busy   = 1'b1;
            end
            c_st_done: begin
                done   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign HWDATA = r_buf;
    assign HBURST = 3'b000;
    assign HSIZE  = 3'b010;
    assign error  = r_error;

endmodule
`default_nettype wire
